// File: rtl/ysyx_25030085_dmem_responder_if.sv
// Request/response channel between the LSU (master) and the data-memory responder (slave).
interface ysyx_25030085_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_memop, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_memop, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_25030085_dmem_responder.sv
// Multi-cycle data-memory slave: one outstanding load/store, programmable wait, then a
// registered response with sign/zero-extended load data or an access-fault flag.
module ysyx_25030085_dmem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    ysyx_25030085_dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_wen;
    logic [2:0]  lat_memop;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] memop,
                                                 input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (memop)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic access_fault(input logic wen, input logic [2:0] memop,
                                          input logic [1:0] lane, input logic in_range);
        logic bad;
        case (memop)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lane[0];
            3'b010:         bad = (lane != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad | (wen & memop[2]) | ~in_range;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] memop, input logic [1:0] lane);
        case (memop[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    logic        accept;
    logic        commit;
    logic        cur_wen;
    logic [2:0]  cur_memop;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] offset;
    logic        in_range;
    logic [IDX_W-1:0] idx;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign commit        = (accept && (LATENCY == 0)) || (state == WAIT && cnt == 4'd1);

    // A zero-latency accept commits on the accept edge, before the latch holds the request.
    always_comb begin
        cur_wen   = lat_wen;
        cur_memop = lat_memop;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_wen   = bus.req_wen;
            cur_memop = bus.req_memop;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
    end

    assign offset   = cur_addr - BASE;
    assign in_range = offset < 32'(4 * DEPTH);
    assign idx      = offset[IDX_W+1:2];
    assign fault    = access_fault(cur_wen, cur_memop, cur_addr[1:0], in_range);
    assign be       = store_be(cur_memop, cur_addr[1:0]);

    always_comb begin
        case (cur_memop[1:0])
            2'b00:   wdata_rep = {4{cur_wdata[7:0]}};
            2'b01:   wdata_rep = {2{cur_wdata[15:0]}};
            default: wdata_rep = cur_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && cur_wen && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_wen   <= bus.req_wen;
                        lat_memop <= bus.req_memop;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        cnt       <= 4'(LATENCY);
                        state     <= WAIT;
                    end
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: begin
                    if (bus.rsp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= fault;
                resp_rdata <= (fault || cur_wen) ? 32'd0
                                                 : load_extract(mem[idx], cur_memop, cur_addr[1:0]);
            end
        end
    end

    assign bus.rsp_valid = resp_valid;
    assign bus.rsp_rdata = resp_rdata;
    assign bus.rsp_err   = resp_err;
endmodule
